// File: rtl/pow2_pkg.sv
// pow2_pkg -- shared constants for the pow2_approx pipeline.
//   DATA_W  : total word width of exponent and result (Q4.12)
//   FRAC_W  : number of fractional bits
//   INT_W   : number of integer bits (signed on the input side)
//   ONE_Q   : 1.0 in Q4.12
//   SAT_Q   : saturated result (largest representable value)
//   LATENCY : rising edges from the capture edge to the edge that asserts valid,
//             counting both of those edges
package pow2_pkg;

    localparam int          DATA_W  = 16;
    localparam int          FRAC_W  = 12;
    localparam int          INT_W   = DATA_W - FRAC_W;
    localparam logic [15:0] ONE_Q   = 16'h1000;
    localparam logic [15:0] SAT_Q   = 16'hFFFF;
    localparam int          LATENCY = 2;

endpackage

// File: rtl/pow2_shift.sv
// pow2_shift -- combinational core of the 2^x approximation.
//   int_part : integer part of x, two's complement bit pattern (floor of x)
//   frac     : fractional part of x, unsigned
//   result   : (1 + frac) scaled by 2^int_part, truncated, saturated to all-ones
//
// The integer part has only 2**INT_W possible values, so every shift is a
// constant: one candidate per integer value is built and int_part selects it.
module pow2_shift #(
    parameter int DATA_W = pow2_pkg::DATA_W,
    parameter int FRAC_W = pow2_pkg::FRAC_W
) (
    input  logic [DATA_W-FRAC_W-1:0] int_part,
    input  logic [FRAC_W-1:0]        frac,
    output logic [DATA_W-1:0]        result
);

    localparam int INT_W = DATA_W - FRAC_W;
    // Largest left shift whose result still fits in DATA_W bits.
    localparam int MAX_SH = DATA_W - FRAC_W - 1;

    // Mantissa 1.frac in Q1.FRAC_W: linear approximation of 2^frac.
    logic [FRAC_W:0]   mant;
    logic [DATA_W-1:0] cand [2**INT_W];

    assign mant = {1'b1, frac};

    genvar gi;
    generate
        for (gi = 0; gi < 2**INT_W; gi++) begin : g_cand
            // Signed interpretation of the candidate index.
            localparam int SH = (gi < 2**(INT_W-1)) ? gi : gi - 2**INT_W;
            if (SH > MAX_SH) begin : g_sat
                assign cand[gi] = {DATA_W{1'b1}};
            end else if (SH >= 0) begin : g_left
                assign cand[gi] = DATA_W'(mant) << SH;
            end else begin : g_right
                assign cand[gi] = DATA_W'(mant) >> (-SH);
            end
        end
    endgenerate

    assign result = cand[int_part];

endmodule

// File: rtl/pow2_approx.sv
// pow2_approx -- two-stage pipelined approximation of 2^x.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   en     : global enable; low freezes every stage and masks valid
//   ready  : input strobe; in_x is captured on an edge with en=1 and ready=1
//   in_x   : exponent x, signed Q4.12
//   pow2_x : approximate 2^x, unsigned Q4.12, held between valid pulses
//   valid  : marks pow2_x/out_x as a new result
//   out_x  : the in_x that produced pow2_x
//
// Stage 1 holds the captured exponent; stage 2 holds the result. A result is
// asserted by the edge after its capture edge. While en=0 the stage-2 valid
// flag holds but the valid output is masked; it is released by the next
// enabled edge, so each result is seen on exactly one enabled edge.
module pow2_approx #(
    parameter int DATA_W = pow2_pkg::DATA_W,
    parameter int FRAC_W = pow2_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ready,
    input  logic [DATA_W-1:0] in_x,
    output logic [DATA_W-1:0] pow2_x,
    output logic              valid,
    output logic [DATA_W-1:0] out_x
);

    logic [DATA_W-1:0] s1_x_reg;
    logic              s1_vld_reg;
    logic [DATA_W-1:0] pow2_reg;
    logic [DATA_W-1:0] out_x_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] shift_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x_reg   <= '0;
            s1_vld_reg <= 1'b0;
            pow2_reg   <= '0;
            out_x_reg  <= '0;
            valid_reg  <= 1'b0;
        end else if (en) begin
            // Stage 1: a strobe-less enabled edge loads a bubble.
            s1_vld_reg <= ready;
            if (ready) begin
                s1_x_reg <= in_x;
            end
            // Stage 2: only real results overwrite the outputs.
            valid_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                pow2_reg  <= shift_out;
                out_x_reg <= s1_x_reg;
            end
        end
    end

    pow2_shift #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_shift (
        .int_part (s1_x_reg[DATA_W-1:FRAC_W]),
        .frac     (s1_x_reg[FRAC_W-1:0]),
        .result   (shift_out)
    );

    assign pow2_x = pow2_reg;
    assign out_x  = out_x_reg;
    assign valid  = valid_reg & en;

endmodule

// File: tb/tb_pow2_approx.sv
// tb_pow2_approx -- self-checking bench for pow2_approx.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same
// point, reflecting the edge just taken and the enable applied to it.
module tb_pow2_approx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ready;
    logic [15:0] in_x;
    logic [15:0] pow2_x;
    logic        valid;
    logic [15:0] out_x;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] x;
        int          stamp;
    } cap_t;

    always #5 clk = ~clk;

    pow2_approx dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ready  (ready),
        .in_x   (in_x),
        .pow2_x (pow2_x),
        .valid  (valid),
        .out_x  (out_x)
    );

    // Reference: 2^x ~= (1 + F) * 2^I with I = floor(x), F = x - I,
    // scaled to Q4.12, truncated, saturated at 0xFFFF for x >= 4.0.
    function automatic logic [15:0] ref_pow2(input logic [15:0] x);
        int     xv;
        int     f;
        int     i_part;
        int     m;
        longint v;
        xv     = int'($signed(x));
        f      = int'(x[11:0]);
        i_part = (xv - f) / 4096;
        m      = 4096 + f;
        if (i_part >= 4) return 16'hFFFF;
        if (i_part >= 0) v = longint'(m) * (longint'(1) << i_part);
        else             v = longint'(m) / (longint'(1) << (-i_part));
        return 16'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; ready = 1'b1; in_x = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({valid, pow2_x, out_x} !== 33'h0) begin
                $display("FAIL reset_state: got valid=%b pow2=%h out=%h want 0/0000/0000", valid, pow2_x, out_x);
            end else n_pass++;
        end
        rst = 1'b1;
    endtask

    task automatic test_first_capture();
        in_x = 16'h0000; ready = 1'b1; en = 1'b1;
        step();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL first_capture_early: valid=%b want 0", valid);
        else n_pass++;
        ready = 1'b0; in_x = 16'($urandom);
        step();
        $display("xact in=0000 pow2=%h out=%h valid=%b", pow2_x, out_x, valid);
        n_checks++;
        if ({valid, pow2_x, out_x} !== {1'b1, 16'h1000, 16'h0000})
            $display("FAIL first_capture: got %b/%h/%h want 1/1000/0000", valid, pow2_x, out_x);
        else n_pass++;
        step();
        n_checks++;
        if ({valid, pow2_x, out_x} !== {1'b0, 16'h1000, 16'h0000})
            $display("FAIL first_capture_hold: got %b/%h/%h want 0/1000/0000", valid, pow2_x, out_x);
        else n_pass++;
    endtask

    // Streams four strobes back to back and expects four consecutive pulses.
    task automatic run_burst(input string name, input logic [15:0] xs [4], input logic [15:0] ys [4]);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin ready = 1'b1; in_x = xs[i]; end
            else begin ready = 1'b0; in_x = 16'($urandom); end
            step();
            if (i >= 1 && i <= 4) begin
                $display("xact %s in=%h pow2=%h valid=%b", name, xs[i-1], pow2_x, valid);
                n_checks++;
                if ({valid, pow2_x, out_x} !== {1'b1, ys[i-1], xs[i-1]})
                    $display("FAIL %s[%0d]: got %b/%h/%h want 1/%h/%h", name, i-1, valid, pow2_x, out_x, ys[i-1], xs[i-1]);
                else n_pass++;
            end else if (i == 5) begin
                n_checks++;
                if (valid !== 1'b0) $display("FAIL %s_tail: valid=%b want 0", name, valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        xs = '{16'h1000, 16'h0800, 16'hF000, 16'hF800};
        ys = '{16'h2000, 16'h1800, 16'h0800, 16'h0C00};
        run_burst("back_to_back", xs, ys);
    endtask

    task automatic test_boundaries();
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        xs = '{16'h3FFF, 16'h4000, 16'h7FFF, 16'h8000};
        ys = '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h0010};
        run_burst("boundary", xs, ys);
    endtask

    task automatic test_stall();
        en = 1'b1; ready = 1'b1; in_x = 16'h1000;
        step();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL stall_capture: valid=%b want 0", valid);
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_x = 16'($urandom);
            step();
            n_checks++;
            if (valid !== 1'b0) $display("FAIL stall_hold[%0d]: valid=%b want 0", i, valid);
            else n_pass++;
        end
        en = 1'b1; ready = 1'b0;
        step();
        $display("xact stall in=1000 pow2=%h valid=%b", pow2_x, valid);
        n_checks++;
        if ({valid, pow2_x, out_x} !== {1'b1, 16'h2000, 16'h1000})
            $display("FAIL stall_release: got %b/%h/%h want 1/2000/1000", valid, pow2_x, out_x);
        else n_pass++;
        step();
        n_checks++;
        if ({valid, pow2_x, out_x} !== {1'b0, 16'h2000, 16'h1000})
            $display("FAIL stall_once: got %b/%h/%h want 0/2000/1000", valid, pow2_x, out_x);
        else n_pass++;
    endtask

    task automatic test_reset_midway();
        int pulses;
        en = 1'b1; ready = 1'b1; in_x = 16'h1000;
        step();
        ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({valid, pow2_x, out_x} !== 33'h0)
            $display("FAIL reset_async: got %b/%h/%h want 0/0000/0000", valid, pow2_x, out_x);
        else n_pass++;
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (valid) pulses++;
        end
        n_checks++;
        if ({pulses, pow2_x, out_x} !== {32'd0, 16'h0, 16'h0})
            $display("FAIL reset_flush: pulses=%0d pow2=%h out=%h want 0/0000/0000", pulses, pow2_x, out_x);
        else n_pass++;
    endtask

    // Random enable/strobe traffic against a capture-stamp scoreboard: a value
    // captured on enabled edge n must emerge on enabled edge n+1.
    task automatic test_random();
        cap_t        q[$];
        cap_t        c;
        int          n_en;
        logic        e_valid;
        logic [15:0] e_pow, e_out, x;
        logic        e, r;
        n_en = 0; e_pow = 16'h0; e_out = 16'h0;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            en = e; ready = r; in_x = x;
            step();
            e_valid = 1'b0;
            if (e) begin
                n_en++;
                if (q.size() > 0 && q[0].stamp == n_en - 1) begin
                    c = q.pop_front();
                    e_valid = 1'b1;
                    e_pow = ref_pow2(c.x);
                    e_out = c.x;
                end
                if (r) q.push_back('{x: x, stamp: n_en});
            end
            n_checks++;
            if ({valid, pow2_x, out_x} !== {e_valid, e_pow, e_out})
                $display("FAIL random[%0d]: got %b/%h/%h want %b/%h/%h", i, valid, pow2_x, out_x, e_valid, e_pow, e_out);
            else n_pass++;
        end
    endtask

    task automatic test_sweep();
        int pulses = 0;
        int errs   = 0;
        logic [15:0] prev;
        en = 1'b1;
        for (int i = 0; i <= 65536; i++) begin
            if (i < 65536) begin ready = 1'b1; in_x = 16'(i); end
            else ready = 1'b0;
            step();
            if (i >= 1) begin
                prev = 16'(i - 1);
                if (valid) pulses++;
                n_checks++;
                if ({valid, pow2_x, out_x} !== {1'b1, ref_pow2(prev), prev}) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL sweep x=%h: got %b/%h/%h want 1/%h/%h", prev, valid, pow2_x, out_x, ref_pow2(prev), prev);
                end else n_pass++;
            end
        end
        ready = 1'b0;
        step();
        if (valid) pulses++;
        $display("xact sweep pulses=%0d mismatches=%0d", pulses, errs);
        n_checks++;
        if (pulses !== 65536) $display("FAIL sweep_count: pulses=%0d want 65536", pulses);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ready = 1'b0; in_x = 16'h0;
        #1;
        test_reset();
        test_first_capture();
        test_back_to_back();
        test_boundaries();
        test_stall();
        test_reset_midway();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pow2_approx.md
POW2_APPROX -- requirements
Module: pow2_approx

Interface
REQ-001 Parameter DATA_W, 16, total word width (Q4.12).
REQ-002 Parameter FRAC_W, 12, fractional bits.
REQ-003 clk  input  1  single clock; all registers update on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; one clock domain, no other clock.
REQ-005 en  input  1  global enable; 0 stalls the pipeline.
REQ-006 ready  input  1  input strobe; in_x is captured on a rising edge where en=1 and ready=1.
REQ-007 in_x  input  DATA_W  exponent x, signed Q4.12 (-8.0 .. +7.99976).
REQ-008 pow2_x  output  DATA_W  approximate 2^x, unsigned Q4.12 (0 .. 15.99976).
REQ-009 valid  output  1  one-cycle pulse marking pow2_x/out_x as a new result.
REQ-010 out_x  output  DATA_W  copy of the in_x that produced pow2_x, aligned with valid.

Function
REQ-011 Split x into int part I = signed x[15:12] (floor) and fraction F = x[11:0].
REQ-012 Mantissa M = 4096 + F (13 bits, Q1.12); linear approximation 2^F ~= 1+F.
REQ-013 I >= 0 and I <= 3: pow2_x = M << I (fits 16 bits, max 0xFFF8).
REQ-014 I < 0: pow2_x = M >> (-I), truncating; I = -8 yields minimum 0x0010.
REQ-015 I >= 4 (x >= 4.0): pow2_x saturates to 0xFFFF.
REQ-016 Pipeline: stage 1 registers in_x on capture; stage 2 registers pow2_x, out_x, valid.
REQ-017 Latency exactly 2 rising edges from capture edge to the edge asserting valid.
REQ-018 Throughput one input per cycle; back-to-back strobes produce back-to-back valid pulses in order.
REQ-019 ready=0 with en=1: a bubble advances; valid is 0 for the corresponding output cycle.
REQ-020 en=0: no capture, all stage registers hold, valid output forced 0; pending results emerge unchanged once en returns to 1.
REQ-021 pow2_x and out_x hold their last values between valid pulses.
REQ-022 No backpressure from downstream; consumer samples on valid.

Reset
REQ-023 rst=0 asynchronously clears pow2_x, out_x, valid and all stage registers (including stage-valid flags) to 0.
REQ-024 Reset mid-operation discards in-flight data; no valid pulse results from inputs captured before reset.
REQ-025 First capture is possible on the first rising edge after rst returns to 1.

Structure
REQ-026 Shared package pow2_pkg holds FRAC_W, ONE_Q = 16'h1000, SAT_Q = 16'hFFFF, LATENCY = 2.
REQ-027 One combinational sub-module pow2_shift (in: I, F; out: saturated 16-bit result) between the stage registers.
REQ-028 Implementation 120-400 lines RTL total.

Verification
REQ-029 Reset then en=1, in_x=0x0000 strobed -> two edges later valid=1, pow2_x=0x1000, out_x=0x0000.
REQ-030 Back-to-back 0x1000, 0x0800, 0xF000, 0xF800 -> pow2_x 0x2000, 0x1800, 0x0800, 0x0C00 on four consecutive valid cycles.
REQ-031 Boundaries: 0x3FFF -> 0xFFF8; 0x4000 -> 0xFFFF; 0x7FFF -> 0xFFFF; 0x8000 -> 0x0010.
REQ-032 Strobe 0x1000, drop en for 3 cycles after capture -> valid stays 0 during stall; 0x2000 appears with valid after en returns, exactly once.
REQ-033 Strobe 0x1000 then assert rst=0 one cycle later -> outputs 0 immediately, no valid after reset release.
REQ-034 Sweep all 65536 inputs against a reference model of REQ-011..015 -> zero mismatches, one valid per strobe.
